bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Clocked successor to the shared-unit bus: multiplexes N requesting users onto one shared
//  execution unit and routes each result back to the user that issued it. Adds round-robin
//  or fixed-priority arbitration and up to DEPTH in-flight requests, tracked by an in-order
//  tag FIFO. Sits between core-side users and one shared functional unit.
// PARAMETERS
//  N        2    number of users (N>=2)
//  INPUT    32   request payload width (bits)
//  OUTPUT   32   response payload width (bits)
//  DEPTH    4    max outstanding requests (power of 2, >=1)
//  RR_MODE  1    1 = round-robin, 0 = fixed priority (lowest index wins)
// PORTS
//  clk          in   1              clock, all state on rising edge
//  reset_n      in   1              asynchronous active-low reset
//  req_valid    in   N              user i offers a request
//  req_ready    out  N              user i request accepted this cycle
//  req_data     in   N x INPUT      user request payloads
//  rsp_valid    out  N              response for user i present
//  rsp_ready    in   N              user i accepts response
//  rsp_data     out  N x OUTPUT     response payload (broadcast, qualify with rsp_valid)
//  in_valid     out  1              request to shared unit
//  in_ready     in   1              shared unit accepts
//  in_data      out  INPUT          selected request payload
//  out_valid    in   1              shared unit result present
//  out_ready    out  1              result consumed
//  out_data     in   OUTPUT         result payload
//  outstanding  out  $clog2(DEPTH+1) in-flight count
//  spurious     out  1              sticky: result arrived with nothing in flight
// BEHAVIOUR
//  Reset (async, reset_n=0): tag FIFO emptied, outstanding=0, rr pointer=0, spurious=0;
//   all outputs combinationally derived -> req_ready=0, rsp_valid=0, in_valid=0 while empty/idle.
//   Requests in flight at reset are discarded; late results then hit the spurious rule.
//  Arbitration (combinational, same cycle): grant g = first i with req_valid[i] searching from
//   ptr upward mod N (RR_MODE=1) or from 0 (RR_MODE=0). full = (outstanding==DEPTH).
//   in_valid = |req_valid & !full; in_data = req_data[g]; req_ready[g] = in_ready & !full;
//   req_ready[j!=g] = 0. Grant must not depend on in_ready (no valid/ready loop).
//  Issue handshake (in_valid & in_ready): push g into tag FIFO; RR_MODE=1: ptr <= (g+1) mod N.
//   ptr unchanged on cycles with no handshake. Zero added latency on request path.
//  Shared unit must return results in issue order; head tag h = FIFO head.
//  Return: if !empty: rsp_valid[h] = out_valid, others 0; rsp_data = out_data;
//   out_ready = rsp_ready[h]; handshake pops head. Zero added latency on response path.
//  Spurious: if empty & out_valid: out_ready=1 (drain), rsp_valid=0, spurious <= 1 (sticky
//   until reset).
//  Simultaneous push+pop: outstanding unchanged, both take effect. When full, push is blocked
//   even if a pop happens the same cycle (no out->in combinational path).
//  Pointers wrap mod DEPTH; outstanding never exceeds DEPTH nor underflows.
//  Holding: a user keeping req_valid high with no grant keeps its payload stable; in RR mode
//   any continuously requesting user is granted within N issue handshakes.
// TESTING
//  1 Reset: hold reset_n=0 with req_valid=2'b11 -> in_valid=1 only after release? No:
//    in_valid=1 allowed (FIFO empty), outstanding=0, spurious=0, rsp_valid=0.
//  2 RR fairness N=2: req_valid=11, in_ready=1 for 4 cycles -> grants 0,1,0,1; DEPTH=4 fills,
//    5th cycle req_ready=00, in_valid=0.
//  3 Fixed priority RR_MODE=0: req_valid=11 continuously -> user 0 granted every cycle.
//  4 Routing: issue user1 A=0x11, user0 B=0x22; unit returns 0xAA,0xBB -> rsp_valid[1] with
//    0xAA first, then rsp_valid[0] with 0xBB; outstanding 2->1->0.
//  5 Backpressure: rsp_ready[h]=0 for 3 cycles with out_valid=1 -> out_ready=0, no pop; full
//    FIFO plus same-cycle pop -> no push that cycle, push next cycle.
//  6 Spurious + reset mid-op: 2 in flight, pulse reset_n low, then out_valid=1 ->
//    out_ready=1, rsp_valid=0, spurious=1 and stays 1.

Source files
------------

// File: rtl/bus_rr_arbiter_if.sv
// Bus between N core-side users, the arbiter, and one shared functional unit.
// master = arbiter side, slave = users plus shared unit.
interface bus_rr_arbiter_if #(
  parameter int N      = 2,
  parameter int INPUT  = 32,
  parameter int OUTPUT = 32
);
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N-1:0][INPUT-1:0]  req_data;
  logic [N-1:0]             rsp_valid;
  logic [N-1:0]             rsp_ready;
  logic [N-1:0][OUTPUT-1:0] rsp_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [INPUT-1:0]         in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUTPUT-1:0]        out_data;

  modport master (
    input  req_valid, req_data, rsp_ready, in_ready, out_valid, out_data,
    output req_ready, rsp_valid, rsp_data, in_valid, in_data, out_ready
  );

  modport slave (
    output req_valid, req_data, rsp_ready, in_ready, out_valid, out_data,
    input  req_ready, rsp_valid, rsp_data, in_valid, in_data, out_ready
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Multiplexes N users onto one shared unit with round-robin or fixed-priority grant;
// an in-order tag FIFO routes each result back to the user that issued it.
module bus_rr_arbiter #(
  parameter int N       = 2,
  parameter int INPUT   = 32,
  parameter int OUTPUT  = 32,
  parameter int DEPTH   = 4,
  parameter int RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  bus_rr_arbiter_if.master           bus,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       spurious
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0] ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          spurious_reg;
  logic [IW-1:0] tag_mem [DEPTH];

  logic [IW-1:0] grant;
  logic [IW-1:0] head;
  logic          any_req;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // First requester at or after start, wrapping mod N.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] valid, input logic [IW-1:0] start);
    logic [IW-1:0] sel;
    logic          found;
    logic [IW:0]   idx;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, start} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!found && valid[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
    return sel;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant depends only on req_valid and the pointer, never on in_ready.
  always_comb begin
    any_req       = |bus.req_valid;
    full          = (count_reg == CW'(DEPTH));
    empty         = (count_reg == '0);
    grant         = pick(bus.req_valid, (RR_MODE != 0) ? ptr_reg : '0);
    head          = tag_mem[rd_ptr_reg];
    bus.in_valid  = any_req & ~full;
    bus.in_data   = bus.req_data[grant];
    bus.req_ready = '0;
    if (any_req && !full && bus.in_ready) bus.req_ready[grant] = 1'b1;
    bus.rsp_valid = '0;
    if (!empty) bus.rsp_valid[head] = bus.out_valid;
    // With nothing in flight the unit's output is drained and flagged.
    bus.out_ready = empty ? 1'b1 : bus.rsp_ready[head];
    push          = bus.in_valid & bus.in_ready;
    pop           = bus.out_valid & bus.out_ready & ~empty;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_rsp
    assign bus.rsp_data[gi] = bus.out_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      spurious_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wrap_inc(wr_ptr_reg);
        if (RR_MODE != 0) ptr_reg <= (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
      end
      if (pop) rd_ptr_reg <= wrap_inc(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;
      if (empty && bus.out_valid) spurious_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_reg] <= grant;
  end

  assign outstanding = count_reg;
  assign spurious    = spurious_reg;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and checks both
// every cycle against a queue-based model, plus hand-computed directed expectations.
module tb_bus_rr_arbiter;
  localparam int N     = 2;
  localparam int IW    = 32;
  localparam int OW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         rsp_ready = '0;
  logic [N-1:0][IW-1:0] req_data  = '0;
  logic                 in_ready  = 1'b0;
  logic                 out_valid = 1'b0;
  logic [OW-1:0]        out_data  = '0;

  bus_rr_arbiter_if #(.N(N), .INPUT(IW), .OUTPUT(OW)) bus_a ();
  bus_rr_arbiter_if #(.N(N), .INPUT(IW), .OUTPUT(OW)) bus_b ();
  logic [CW-1:0] outstanding_a, outstanding_b;
  logic          spurious_a, spurious_b;

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_data  = req_data;
  assign bus_a.rsp_ready = rsp_ready;
  assign bus_a.in_ready  = in_ready;
  assign bus_a.out_valid = out_valid;
  assign bus_a.out_data  = out_data;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_data  = req_data;
  assign bus_b.rsp_ready = rsp_ready;
  assign bus_b.in_ready  = in_ready;
  assign bus_b.out_valid = out_valid;
  assign bus_b.out_data  = out_data;

  bus_rr_arbiter #(.N(N), .INPUT(IW), .OUTPUT(OW), .DEPTH(DEPTH), .RR_MODE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.master),
    .outstanding(outstanding_a), .spurious(spurious_a)
  );
  bus_rr_arbiter #(.N(N), .INPUT(IW), .OUTPUT(OW), .DEPTH(DEPTH), .RR_MODE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.master),
    .outstanding(outstanding_b), .spurious(spurious_b)
  );

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic [N-1:0]         o_req_ready [2];
  logic [N-1:0]         o_rsp_valid [2];
  logic                 o_in_valid  [2];
  logic                 o_out_ready [2];
  logic                 o_spurious  [2];
  logic [IW-1:0]        o_in_data   [2];
  logic [N-1:0][OW-1:0] o_rsp_data  [2];
  logic [CW-1:0]        o_count     [2];

  assign o_req_ready[0] = bus_a.req_ready;
  assign o_rsp_valid[0] = bus_a.rsp_valid;
  assign o_in_valid[0]  = bus_a.in_valid;
  assign o_out_ready[0] = bus_a.out_ready;
  assign o_spurious[0]  = spurious_a;
  assign o_in_data[0]   = bus_a.in_data;
  assign o_rsp_data[0]  = bus_a.rsp_data;
  assign o_count[0]     = outstanding_a;
  assign o_req_ready[1] = bus_b.req_ready;
  assign o_rsp_valid[1] = bus_b.rsp_valid;
  assign o_in_valid[1]  = bus_b.in_valid;
  assign o_out_ready[1] = bus_b.out_ready;
  assign o_spurious[1]  = spurious_b;
  assign o_in_data[1]   = bus_b.in_data;
  assign o_rsp_data[1]  = bus_b.rsp_data;
  assign o_count[1]     = outstanding_b;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, int d, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d actual=%0h required=%0h t=%0t", name, d, act, exp, $time);
    end
  endfunction

  // Reference model: pointer per instance and a queue of issuing users in flight.
  int ptr_m [2];
  bit spur_m [2];
  int q0 [$];
  int q1 [$];

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qhead(int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  always @(negedge clk) begin : compare
    int sz, g, hd, idx;
    bit rr, full, any, exp_in_valid, exp_out_ready, do_push, do_pop;
    logic [N-1:0] exp_req_ready, exp_rsp_valid;
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        ptr_m[d]  = 0;
        spur_m[d] = 1'b0;
        if (d == 0) q0.delete(); else q1.delete();
      end
      rr   = (d == 0);
      sz   = qsize(d);
      full = (sz == DEPTH);
      any  = |req_valid;
      g    = -1;
      for (int k = 0; k < N; k++) begin
        idx = ((rr ? ptr_m[d] : 0) + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      hd = (sz > 0) ? qhead(d) : 0;
      exp_in_valid  = any && !full;
      exp_req_ready = '0;
      if (exp_in_valid && in_ready) exp_req_ready[g] = 1'b1;
      exp_rsp_valid = '0;
      if (sz > 0 && out_valid) exp_rsp_valid[hd] = 1'b1;
      exp_out_ready = (sz > 0) ? rsp_ready[hd] : 1'b1;

      chk("outstanding", d, o_count[d], sz);
      chk("spurious", d, o_spurious[d], spur_m[d]);
      chk("in_valid", d, o_in_valid[d], exp_in_valid);
      chk("req_ready", d, o_req_ready[d], exp_req_ready);
      chk("rsp_valid", d, o_rsp_valid[d], exp_rsp_valid);
      chk("out_ready", d, o_out_ready[d], exp_out_ready);
      if (any) chk("in_data", d, o_in_data[d], req_data[g]);
      if (exp_rsp_valid != '0) chk("rsp_data", d, o_rsp_data[d][hd], out_data);

      if (reset_n) begin
        do_pop  = (sz > 0) && out_valid && exp_out_ready;
        do_push = exp_in_valid && in_ready;
        if (do_pop) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (do_push) begin
          if (d == 0) q0.push_back(g); else q1.push_back(g);
          if (rr) ptr_m[d] = (g + 1) % N;
        end
        if (sz == 0 && out_valid) spur_m[d] = 1'b1;
      end
    end
  end

  task automatic drive(input logic rn, input logic [N-1:0] rv, input logic [IW-1:0] d0,
                       input logic [IW-1:0] d1, input logic ir, input logic ov,
                       input logic [OW-1:0] od, input logic [N-1:0] rr);
    @(posedge clk);
    #1;
    reset_n     = rn;
    req_valid   = rv;
    req_data[0] = d0;
    req_data[1] = d1;
    in_ready    = ir;
    out_valid   = ov;
    out_data    = od;
    rsp_ready   = rr;
    #1;
  endtask

  initial begin
    // Held in reset with both users requesting.
    reset_n   = 1'b0;
    req_valid = 2'b11;
    in_ready  = 1'b1;
    #2;
    chk("rst_in_valid", 0, o_in_valid[0], 1'b1);
    chk("rst_outstanding", 0, outstanding_a, 0);
    chk("rst_spurious", 0, spurious_a, 1'b0);
    chk("rst_rsp_valid", 0, o_rsp_valid[0], 2'b00);

    // Alternating round-robin grants vs. fixed priority, then full.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b11, 32'h100 + k, 32'h200 + k, 1'b1, 1'b0, '0, 2'b11);
      chk("rr_grant", 0, o_req_ready[0], (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("fixed_grant", 1, o_req_ready[1], 2'b01);
    end
    drive(1'b1, 2'b11, 32'h1, 32'h2, 1'b1, 1'b0, '0, 2'b11);
    chk("full_req_ready", 0, o_req_ready[0], 2'b00);
    chk("full_in_valid", 0, o_in_valid[0], 1'b0);
    chk("full_count", 0, outstanding_a, 4);

    // Routing: user1 then user0, results come back in issue order.
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b00);
    drive(1'b1, 2'b10, 32'h0, 32'h11, 1'b1, 1'b0, '0, 2'b11);
    chk("route_in_data1", 0, o_in_data[0], 32'h11);
    chk("route_ready1", 0, o_req_ready[0], 2'b10);
    drive(1'b1, 2'b01, 32'h22, 32'h0, 1'b1, 1'b0, '0, 2'b11);
    chk("route_in_data0", 0, o_in_data[0], 32'h22);
    chk("route_count1", 0, outstanding_a, 1);
    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b1, 32'hAA, 2'b11);
    chk("route_rsp_valid_a", 0, o_rsp_valid[0], 2'b10);
    chk("route_rsp_data_a", 0, o_rsp_data[0][1], 32'hAA);
    chk("route_count2", 0, outstanding_a, 2);
    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b1, 32'hBB, 2'b11);
    chk("route_rsp_valid_b", 0, o_rsp_valid[0], 2'b01);
    chk("route_rsp_data_b", 0, o_rsp_data[0][0], 32'hBB);
    chk("route_count3", 0, outstanding_a, 1);
    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b11);
    chk("route_count4", 0, outstanding_a, 0);

    // Response backpressure, then full with a same-cycle pop.
    repeat (4) drive(1'b1, 2'b01, 32'h33, '0, 1'b1, 1'b0, '0, 2'b11);
    repeat (3) begin
      drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b1, 32'hCC, 2'b00);
      chk("bp_out_ready", 0, o_out_ready[0], 1'b0);
      chk("bp_rsp_valid", 0, o_rsp_valid[0], 2'b01);
      chk("bp_count", 0, outstanding_a, 4);
    end
    drive(1'b1, 2'b01, 32'h44, '0, 1'b1, 1'b1, 32'hDD, 2'b11);
    chk("fullpop_in_valid", 0, o_in_valid[0], 1'b0);
    chk("fullpop_req_ready", 0, o_req_ready[0], 2'b00);
    chk("fullpop_out_ready", 0, o_out_ready[0], 1'b1);
    drive(1'b1, 2'b01, 32'h44, '0, 1'b1, 1'b0, '0, 2'b11);
    chk("after_pop_count", 0, outstanding_a, 3);
    chk("after_pop_ready", 0, o_req_ready[0], 2'b01);
    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b11);
    chk("refill_count", 0, outstanding_a, 4);

    // Reset with requests in flight; late result is spurious.
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b00);
    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b1, 32'hEE, 2'b00);
    chk("spur_out_ready", 0, o_out_ready[0], 1'b1);
    chk("spur_rsp_valid", 0, o_rsp_valid[0], 2'b00);
    chk("spur_count", 0, outstanding_a, 0);
    chk("spur_not_yet", 0, spurious_a, 1'b0);
    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b00);
    chk("spur_set", 0, spurious_a, 1'b1);
    chk("spur_set_b", 1, spurious_b, 1'b1);
    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b00);
    chk("spur_sticky", 0, spurious_a, 1'b1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      reset_n   = ($urandom_range(0, 299) != 0);
      req_valid = N'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) req_data[i] = $urandom;
      in_ready  = ($urandom_range(0, 3) != 0);
      out_valid = (q0.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      out_data  = $urandom;
      rsp_ready = N'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    req_valid = '0;
    out_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
